// File: rtl/bitrev_idx_gen.sv
// Index sequencer feeding the BitRev stage of the NWC/NTT datapath.
// Sweeps 0..2^(RADIX_K1*l)-1 one index per cycle with stall, drain and done.
module bitrev_idx_gen #(
    parameter int D_WIDTH  = 12,
    parameter int RADIX_K1 = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [2:0]         l,
    input  logic               hold,
    output logic [D_WIDTH-1:0] idx_out,
    output logic               bitrev_enable,
    output logic [2:0]         l_out,
    output logic               out_valid,
    output logic               busy,
    output logic               done,
    output logic               err
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [D_WIDTH:0] ONE   = {{D_WIDTH{1'b0}}, 1'b1};
    localparam logic [6:0]       W_MAX = 7'(D_WIDTH);
    localparam logic [6:0]       K1    = 7'(RADIX_K1);

    state_t             state;
    state_t             state_nxt;
    logic [D_WIDTH:0]   count;
    logic [D_WIDTH:0]   count_nxt;
    logic [D_WIDTH:0]   last;
    logic [6:0]         w_req;
    logic [6:0]         w_cur;
    logic               legal;
    logic [D_WIDTH-1:0] idx_nxt;
    logic [2:0]         l_nxt;
    logic               en_nxt;
    logic               busy_nxt;
    logic               done_nxt;
    logic               err_nxt;

    // Width of the requested sweep and of the sweep in progress
    assign w_req = K1 * {4'd0, l};
    assign w_cur = K1 * {4'd0, l_out};
    assign legal = (l != 3'd0) && (w_req <= W_MAX);
    // Count is one bit wider than the index so 2^W-1 never wraps
    assign last  = (ONE << w_cur) - ONE;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next state and next registered outputs
    always_comb begin
        state_nxt = state;
        count_nxt = count;
        l_nxt     = l_out;
        idx_nxt   = idx_out;
        en_nxt    = 1'b0;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (legal) begin
                        l_nxt     = l;
                        count_nxt = '0;
                        state_nxt = RUN;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            RUN: begin
                busy_nxt = 1'b1;
                if (!hold) begin
                    idx_nxt = count[D_WIDTH-1:0];
                    en_nxt  = 1'b1;
                    if (count == last) state_nxt = DRAIN;
                    else               count_nxt = count + ONE;
                end
            end
            DRAIN: begin
                busy_nxt  = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                done_nxt  = 1'b1;
                state_nxt = IDLE;
            end
        endcase
    end

    // Output and count registers; out_valid trails enable by BitRev's latency
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count         <= '0;
            idx_out       <= '0;
            bitrev_enable <= 1'b0;
            l_out         <= 3'd0;
            out_valid     <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
        end else begin
            count         <= count_nxt;
            idx_out       <= idx_nxt;
            bitrev_enable <= en_nxt;
            l_out         <= l_nxt;
            out_valid     <= bitrev_enable;
            busy          <= busy_nxt;
            done          <= done_nxt;
            err           <= err_nxt;
        end
    end

endmodule

// File: tb/tb_bitrev_idx_gen.sv
// Bench for bitrev_idx_gen: sweep-level reference model checked every cycle
// plus directed scenarios with hand-computed latencies and counts.
module tb_bitrev_idx_gen;
    localparam int DW = 12;
    localparam int K1 = 4;

    logic          clk;
    logic          rst;
    logic          start;
    logic          hold;
    logic [2:0]    l;
    logic [DW-1:0] idx_out;
    logic          bitrev_enable;
    logic [2:0]    l_out;
    logic          out_valid;
    logic          busy;
    logic          done;
    logic          err;

    bitrev_idx_gen #(.D_WIDTH(DW), .RADIX_K1(K1)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .l             (l),
        .hold          (hold),
        .idx_out       (idx_out),
        .bitrev_enable (bitrev_enable),
        .l_out         (l_out),
        .out_valid     (out_valid),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a sweep is len indices, then one quiet cycle, then done
    int            len    = 0;
    int            issued = 0;
    int            tail   = 0;
    logic [DW-1:0] m_idx  = '0;
    logic          m_en   = 1'b0;
    logic          m_val  = 1'b0;
    logic          m_busy = 1'b0;
    logic          m_done = 1'b0;
    logic          m_err  = 1'b0;
    logic [2:0]    m_l    = 3'd0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            len = 0; issued = 0; tail = 0;
            m_idx = '0; m_en = 0; m_val = 0;
            m_busy = 0; m_done = 0; m_err = 0; m_l = 0;
        end else begin
            m_val  = m_en;
            m_en   = 1'b0;
            m_done = 1'b0;
            m_err  = 1'b0;
            if (len == 0) begin
                m_busy = 1'b0;
                if (start) begin
                    if (l != 0 && K1 * int'(l) <= DW) begin
                        m_l    = l;
                        len    = 1 << (K1 * int'(l));
                        issued = 0;
                        tail   = 0;
                    end else begin
                        m_err = 1'b1;
                    end
                end
            end else if (issued < len) begin
                m_busy = 1'b1;
                if (!hold) begin
                    m_idx = issued[DW-1:0];
                    m_en  = 1'b1;
                    issued++;
                end
            end else begin
                tail++;
                if (tail == 1) begin
                    m_busy = 1'b1;
                end else begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                    len    = 0;
                end
            end
        end
    end

    int n_en = 0, n_val = 0, n_busy = 0, n_done = 0, n_err = 0;

    // Per-cycle comparison against the model, plus activity tallies
    always @(negedge clk) begin
        if (chk_en) begin
            chk("idx_out", idx_out, m_idx);
            chk("bitrev_enable", bitrev_enable, m_en);
            chk("l_out", l_out, m_l);
            chk("out_valid", out_valid, m_val);
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            chk("err", err, m_err);
            n_en   += int'(bitrev_enable);
            n_val  += int'(out_valid);
            n_busy += int'(busy);
            n_done += int'(done);
            n_err  += int'(err);
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_done(input int bound, output int cyc);
        bit found;
        found = 0;
        cyc   = 0;
        for (int i = 0; i < bound; i++) begin
            step();
            cyc++;
            if (done) begin
                found = 1;
                break;
            end
        end
        chk("done_seen", found, 1);
    endtask

    task automatic wait_idx(input int v, input int bound);
        bit found;
        found = 0;
        for (int i = 0; i < bound; i++) begin
            if (bitrev_enable && idx_out == v[DW-1:0]) begin
                found = 1;
                break;
            end
            step();
        end
        chk("idx_reached", found, 1);
    endtask

    int e0, v0, b0, d0, r0, cyc;

    initial begin
        rst = 1'b0; start = 1'b0; hold = 1'b0; l = 3'd0;
        repeat (3) step();
        chk_en = 1'b1;
        step();
        chk("rst_idx", idx_out, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b1;
        step();

        // l=1 plain sweep: 16 issues, 16 valids, done 19 cycles from start
        e0 = n_en; v0 = n_val; d0 = n_done;
        start = 1'b1; l = 3'd1;
        step();
        start = 1'b0;
        wait_done(100, cyc);
        chk("t1_done_lat", cyc + 1, 19);
        step(); step();
        chk("t1_en_cnt", n_en - e0, 16);
        chk("t1_val_cnt", n_val - v0, 16);
        chk("t1_done_cnt", n_done - d0, 1);

        // l=3 full-width sweep
        e0 = n_en; b0 = n_busy;
        start = 1'b1; l = 3'd3;
        step();
        start = 1'b0;
        wait_done(5000, cyc);
        chk("t2_last_idx", idx_out, 4095);
        chk("t2_en_cnt", n_en - e0, 4096);
        chk("t2_busy_cnt", n_busy - b0, 4097);
        step();

        // Three-cycle stall while index 5 is on the bus
        e0 = n_en;
        start = 1'b1; l = 3'd1;
        step();
        start = 1'b0;
        wait_idx(5, 40);
        hold = 1'b1;
        repeat (3) begin
            step();
            chk("hold_en", bitrev_enable, 0);
            chk("hold_idx", idx_out, 5);
        end
        hold = 1'b0;
        step();
        chk("resume_idx", idx_out, 6);
        chk("resume_en", bitrev_enable, 1);
        wait_done(100, cyc);
        step();
        chk("t3_en_cnt", n_en - e0, 16);

        // Illegal stage counts
        e0 = n_en; b0 = n_busy; r0 = n_err;
        start = 1'b1; l = 3'd0;
        step();
        chk("err_l0", err, 1);
        start = 1'b0;
        step();
        chk("err_l0_clr", err, 0);
        start = 1'b1; l = 3'd4;
        step();
        chk("err_l4", err, 1);
        start = 1'b0;
        repeat (4) step();
        chk("t4_err_cnt", n_err - r0, 2);
        chk("t4_en_cnt", n_en - e0, 0);
        chk("t4_busy_cnt", n_busy - b0, 0);

        // Asynchronous reset mid-sweep, then a clean l=2 sweep
        d0 = n_done;
        start = 1'b1; l = 3'd1;
        step();
        start = 1'b0;
        wait_idx(7, 40);
        #2 rst = 1'b0;
        #1;
        chk("arst_idx", idx_out, 0);
        chk("arst_en", bitrev_enable, 0);
        chk("arst_l", l_out, 0);
        chk("arst_busy", busy, 0);
        step(); step();
        rst = 1'b1;
        repeat (20) step();
        chk("arst_no_done", n_done - d0, 0);
        e0 = n_en;
        start = 1'b1; l = 3'd2;
        step();
        start = 1'b0;
        wait_done(400, cyc);
        chk("t5_en_cnt", n_en - e0, 256);
        step();

        // start held high: back-to-back sweeps, one per accepted start
        e0 = n_en; d0 = n_done;
        start = 1'b1; l = 3'd1;
        wait_done(100, cyc);
        chk("t6_first_en", n_en - e0, 16);
        cyc = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            cyc++;
            if (bitrev_enable && idx_out == '0) break;
        end
        chk("t6_restart_lat", cyc, 2);
        start = 1'b0;
        wait_done(100, cyc);
        step();
        chk("t6_en_cnt", n_en - e0, 32);
        chk("t6_done_cnt", n_done - d0, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
